// File: rtl/game_sequencer.sv
// Rhythm-game step sequencer: metronome count-in, then one step pattern
// per beat fetched from a synchronous step memory, then DONE until restarted.
module game_sequencer #(
  parameter int BEAT_DIV = 5000000,
  parameter int COUNT_IN = 4,
  parameter int SONG_LEN = 64,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [3:0]        stepData,
  output logic [ADDR_W-1:0] stepAddr,
  output logic [3:0]        step,
  output logic              beatEn,
  output logic              bpmClk,
  output logic              playing,
  output logic              done
);

  localparam int BC_W  = $clog2(BEAT_DIV);
  localparam int CIN_W = $clog2(COUNT_IN + 1);
  localparam int IDX_W = $clog2(SONG_LEN + 1);

  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BEAT_DIV - 1);
  localparam logic [BC_W-1:0]  BEAT_HALF = BC_W'(BEAT_DIV / 2);
  localparam logic [CIN_W-1:0] CIN_LAST  = CIN_W'(COUNT_IN - 1);
  localparam logic [IDX_W-1:0] SONG_END  = IDX_W'(SONG_LEN);

  typedef enum logic [1:0] {IDLE, COUNTIN, PLAY, DONE} state_t;

  state_t             state, stateNext;
  logic               startQ, startArmed, startPulse;
  logic               wrap, load;
  logic [BC_W-1:0]    beatCnt, beatCntNext;
  logic [CIN_W-1:0]   cinCnt, cinCntNext;
  logic [IDX_W-1:0]   stepIdx, stepIdxNext;
  logic [ADDR_W-1:0]  stepAddrNext;
  logic [3:0]         stepNext;
  logic               beatEnNext;

  // startArmed blocks a start level held high through reset release from
  // looking like a fresh button press on the first edge.
  assign startPulse = start & ~startQ & startArmed;
  assign wrap       = (beatCnt == BEAT_LAST);
  assign bpmClk     = ((state == COUNTIN) || (state == PLAY)) && (beatCnt < BEAT_HALF);

  always_comb begin
    stateNext    = state;
    beatCntNext  = beatCnt;
    cinCntNext   = cinCnt;
    stepIdxNext  = stepIdx;
    stepAddrNext = stepAddr;
    stepNext     = step;
    beatEnNext   = 1'b0;
    load         = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (startPulse) begin
          stateNext    = COUNTIN;
          beatCntNext  = '0;
          cinCntNext   = '0;
          stepIdxNext  = '0;
          stepAddrNext = '0;
          stepNext     = '0;
        end
      end
      COUNTIN: begin
        if (!pause) begin
          beatCntNext = wrap ? '0 : beatCnt + BC_W'(1);
          if (wrap) begin
            cinCntNext = cinCnt + CIN_W'(1);
            if (cinCnt == CIN_LAST) begin
              stateNext = PLAY;
              load      = 1'b1;
            end
          end
        end
      end
      PLAY: begin
        if (!pause) begin
          beatCntNext = wrap ? '0 : beatCnt + BC_W'(1);
          if (wrap) begin
            if (stepIdx == SONG_END) begin
              stateNext = DONE;
              stepNext  = '0;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    // Load edge: the address has been stable a whole beat, so stepData is valid.
    if (load) begin
      stepNext     = stepData;
      stepAddrNext = stepAddr + ADDR_W'(1);
      stepIdxNext  = stepIdx + IDX_W'(1);
      beatEnNext   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      startQ     <= 1'b0;
      startArmed <= 1'b0;
      beatCnt    <= '0;
      cinCnt     <= '0;
      stepIdx    <= '0;
      stepAddr   <= '0;
      step       <= '0;
      beatEn     <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      startQ     <= start;
      startArmed <= 1'b1;
      beatCnt    <= beatCntNext;
      cinCnt     <= cinCntNext;
      stepIdx    <= stepIdxNext;
      stepAddr   <= stepAddrNext;
      step       <= stepNext;
      beatEn     <= beatEnNext;
      playing    <= (stateNext == PLAY);
      done       <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed timing scenarios plus random start/pause/
// reset traffic, checked against a beat-count model of the song.
module tb_game_sequencer;
  localparam int BD  = 8;
  localparam int CIN = 2;
  localparam int SL  = 3;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [3:0]    stepData;
  logic [AW-1:0] stepAddr;
  logic [3:0]    step;
  logic          beatEn, bpmClk, playing, done;

  logic [3:0]    mem [0:3];

  int vectors = 0;
  int miscompares = 0;

  game_sequencer #(.BEAT_DIV(BD), .COUNT_IN(CIN), .SONG_LEN(SL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stepData(stepData),
    .stepAddr(stepAddr), .step(step), .beatEn(beatEn), .bpmClk(bpmClk),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) stepData <= mem[stepAddr];

  // Model: n counts unpaused active cycles since the last start; the song
  // position follows from n / BD (beats elapsed) and n % BD (beat phase).
  bit started, armed, prevStart, expBeatEn;
  int n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      started = 0; armed = 0; prevStart = 0; n = 0; expBeatEn = 0;
    end else begin
      bit sp, active;
      sp        = start && !prevStart && armed;
      prevStart = start;
      armed     = 1;
      active    = started && (n / BD < CIN + SL);
      expBeatEn = 0;
      if (!active) begin
        if (sp) begin started = 1; n = 0; end
      end else if (!pause) begin
        n++;
        expBeatEn = (n % BD == 0) && (n / BD >= CIN) && (n / BD < CIN + SL);
      end
    end
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0]    eStep = '0;
    logic [AW-1:0] eAddr = '0;
    logic          ePlay = 0, eDone = 0, eBpm = 0;
    int k, ph;
    k  = n / BD;
    ph = n % BD;
    if (started) begin
      if (k < CIN) begin
        eBpm = (ph < BD / 2);
      end else if (k < CIN + SL) begin
        eStep = mem[k - CIN];
        eAddr = AW'(k - CIN + 1);
        ePlay = 1;
        eBpm  = (ph < BD / 2);
      end else begin
        eAddr = AW'(SL);
        eDone = 1;
      end
    end
    cmp("step", step, eStep);
    cmp("stepAddr", stepAddr, eAddr);
    cmp("beatEn", beatEn, expBeatEn);
    cmp("bpmClk", bpmClk, eBpm);
    cmp("playing", playing, ePlay);
    cmp("done", done, eDone);
  endtask

  always @(posedge clk) begin
    #2;
    check_all();
  end

  // Leaves the caller 4ns after the n-th following rising edge.
  task automatic adv(input int cnt);
    repeat (cnt) @(posedge clk);
    #4;
  endtask

  initial begin
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1010; mem[3] = 4'b0000;
    #12;
    cmp("rst_step", step, 0);
    cmp("rst_playing", playing, 0);
    cmp("rst_bpm", bpmClk, 0);
    adv(2); reset = 1;
    adv(3);
    // start held high through an asynchronous reset pulse must not start
    start = 1;
    reset = 0; #1;
    cmp("async_beatEn", beatEn, 0);
    cmp("async_done", done, 0);
    adv(1); reset = 1;
    adv(4);
    cmp("held_start_playing", playing, 0);
    cmp("held_start_bpm", bpmClk, 0);

    // normal song
    start = 0; adv(1); start = 1; adv(1);          // E
    cmp("E0_bpm", bpmClk, 1);
    adv(3); cmp("E3_bpm", bpmClk, 1);
    adv(1); cmp("E4_bpm", bpmClk, 0);
    adv(4); cmp("E8_bpm", bpmClk, 1); cmp("E8_playing", playing, 0);
    adv(8); cmp("E16_beatEn", beatEn, 1); cmp("E16_step", step, 4'b0001);
    cmp("E16_playing", playing, 1);
    adv(1); cmp("E17_beatEn", beatEn, 0);
    adv(7); cmp("E24_beatEn", beatEn, 1); cmp("E24_step", step, 4'b0100);
    adv(8); cmp("E32_beatEn", beatEn, 1); cmp("E32_step", step, 4'b1010);
    cmp("E32_addr", stepAddr, 3);
    adv(8); cmp("E40_done", done, 1); cmp("E40_step", step, 0);
    cmp("E40_beatEn", beatEn, 0); cmp("E40_playing", playing, 0);

    // restart from DONE, with a 5-cycle pause in the first played beat
    start = 0; adv(1); start = 1; adv(1);          // D
    cmp("D0_done", done, 0); cmp("D0_addr", stepAddr, 0); cmp("D0_bpm", bpmClk, 1);
    adv(16); cmp("D16_beatEn", beatEn, 1); cmp("D16_step", step, 4'b0001);
    adv(1); pause = 1;
    adv(3); cmp("pause_step", step, 4'b0001); cmp("pause_bpm", bpmClk, 1);
    adv(2); pause = 0;
    adv(2); cmp("D24_beatEn", beatEn, 0);
    adv(5); cmp("D29_beatEn", beatEn, 1); cmp("D29_step", step, 4'b0100);
    adv(20);

    // start retoggle mid-song is ignored; then reset mid-song
    start = 0; adv(1); start = 1; adv(1);          // E
    adv(19); start = 0;
    adv(1); start = 1;
    adv(4); cmp("ign_beatEn", beatEn, 1); cmp("ign_addr", stepAddr, 2);
    adv(2); reset = 0; #1;
    cmp("midrst_step", step, 0); cmp("midrst_playing", playing, 0);
    cmp("midrst_addr", stepAddr, 0); cmp("midrst_bpm", bpmClk, 0);
    adv(1); reset = 1;
    adv(3); cmp("post_rst_playing", playing, 0); cmp("post_rst_bpm", bpmClk, 0);

    // random traffic with a fresh song pattern
    reset = 0;
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom);
    adv(1); reset = 1;
    repeat (3000) begin
      adv(1);
      if (!reset) reset = 1;
      else if ($urandom_range(0, 299) == 0) reset = 0;
      if ($urandom_range(0, 7) == 0) start = ~start;
      pause = ($urandom_range(0, 4) == 0);
    end
    adv(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
